// File: rtl/wbus_pkg.sv
// rtl/wbus_pkg.sv - shared W-bus constants and responder state encoding
package wbus_pkg;

  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 28;
  localparam int DATA_W  = 32;

  localparam logic [3:0] WBUS_IDLE_TAG = 4'h0;
  localparam logic [3:0] CPU_REG_TAG   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10,
    ST_HOLD = 2'b11
  } wbus_state_e;

  function automatic logic tag_is_claimable(input logic [3:0] tag);
    return (tag != WBUS_IDLE_TAG) && (tag != CPU_REG_TAG);
  endfunction

endpackage

// File: rtl/wbus_sram.sv
// rtl/wbus_sram.sv - single-port synchronous word RAM with registered read
import wbus_pkg::*;

module wbus_sram #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  output logic [DATA_W-1:0]    o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_W-1:0] r_rdata;

  // Contents are deliberately not reset; only the controller state is.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wbus_mem_responder.sv
// rtl/wbus_mem_responder.sv - W-bus responder serving one SRAM word per request
import wbus_pkg::*;

module wbus_mem_responder #(
  parameter logic [3:0] BASE_TAG    = 4'h1,
  parameter int         ADDR_BITS   = 8,
  parameter int         WAIT_CYCLES = 1
) (
  input  logic        W_CLK,
  input  logic        W_RST,
  input  logic [31:0] W_ADDR,
  input  logic        W_WRITE,
  input  logic [31:0] W_DATA_I,
  output logic [31:0] W_DATA_O,
  output logic        W_ACK
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  wbus_state_e          r_state;
  wbus_state_e          w_next_state;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_idx;
  logic                 r_write;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_ack;
  logic [DATA_W-1:0]    r_rdata_o;

  logic                 w_req;
  logic [ADDR_BITS-1:0] w_idx_in;
  logic [ADDR_BITS-1:0] w_sram_addr;
  logic                 w_sram_we;
  logic [DATA_W-1:0]    w_sram_rdata;
  logic                 w_unused;

  assign w_req    = (W_ADDR[TAG_MSB:TAG_LSB] == BASE_TAG);
  assign w_idx_in = W_ADDR[ADDR_BITS+1:2];
  assign w_unused = ^{W_ADDR[TAG_LSB-1:ADDR_BITS+2], W_ADDR[1:0], tag_is_claimable(BASE_TAG)};

  // The RAM read is registered, so the index goes in one edge ahead of the
  // ACK edge: live from the bus while idle, latched afterwards.
  assign w_sram_addr = (r_state == ST_IDLE) ? w_idx_in : r_idx;
  assign w_sram_we   = (r_state == ST_ACK) && r_write;

  wbus_sram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_sram (
    .i_clk  (W_CLK),
    .i_we   (w_sram_we),
    .i_addr (w_sram_addr),
    .i_wdata(r_wdata),
    .o_rdata(w_sram_rdata)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next_state = (WAIT_LOAD == 4'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_next_state = ST_ACK;
        end
      end
      ST_ACK:  w_next_state = ST_HOLD;
      ST_HOLD: begin
        if (!w_req) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_ack     <= 1'b0;
      r_rdata_o <= '0;
    end else begin
      r_state <= w_next_state;
      r_ack   <= (r_state == ST_ACK);
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_idx   <= w_idx_in;
            r_write <= W_WRITE;
            r_wdata <= W_DATA_I;
            r_cnt   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (!w_req) begin
            r_cnt <= 4'd0;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          if (!r_write) begin
            r_rdata_o <= w_sram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign W_ACK    = r_ack;
  assign W_DATA_O = r_rdata_o;

endmodule

// File: tb/tb_wbus_mem_responder.sv
// tb/tb_wbus_mem_responder.sv - randomized self-checking bench for wbus_mem_responder
`timescale 1ns/1ps

module tb_wbus_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr [3];
  logic [31:0] din  [3];
  logic [31:0] dout [3];
  logic        wr   [3];
  logic        ack  [3];

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mdl    [3][256];
  bit          vld    [3][256];
  logic [31:0] last_rd[3];

  always #5 clk = ~clk;

  wbus_mem_responder #(.BASE_TAG(4'h1), .ADDR_BITS(8), .WAIT_CYCLES(1)) u_w1 (
    .W_CLK(clk), .W_RST(rst), .W_ADDR(addr[0]), .W_WRITE(wr[0]),
    .W_DATA_I(din[0]), .W_DATA_O(dout[0]), .W_ACK(ack[0]));
  wbus_mem_responder #(.BASE_TAG(4'h1), .ADDR_BITS(8), .WAIT_CYCLES(4)) u_w4 (
    .W_CLK(clk), .W_RST(rst), .W_ADDR(addr[1]), .W_WRITE(wr[1]),
    .W_DATA_I(din[1]), .W_DATA_O(dout[1]), .W_ACK(ack[1]));
  wbus_mem_responder #(.BASE_TAG(4'h1), .ADDR_BITS(8), .WAIT_CYCLES(0)) u_w0 (
    .W_CLK(clk), .W_RST(rst), .W_ADDR(addr[2]), .W_WRITE(wr[2]),
    .W_DATA_I(din[2]), .W_DATA_O(dout[2]), .W_ACK(ack[2]));

  function automatic int wc(input int u);
    case (u)
      0:       return 1;
      1:       return 4;
      default: return 0;
    endcase
  endfunction

  // Drives one request, holds it `extra` cycles past the expected ACK, then
  // releases the bus for one edge. Inputs are scrambled after the sampling edge.
  task automatic xfer(input int u, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input int extra, output int lat, output int acks, output logic [31:0] rd);
    lat = -1; acks = 0; rd = 32'h0;
    @(negedge clk);
    addr[u] = a; wr[u] = w; din[u] = d;
    for (int n = 1; n <= wc(u) + 2 + extra; n++) begin
      @(negedge clk);
      if (ack[u] === 1'b1) begin
        acks++;
        if (lat < 0) begin
          lat = n;
          rd  = dout[u];
        end
      end
      if (n == 1) begin
        din[u]  = ~d;
        addr[u] = a ^ 32'h0000_00FC;
        wr[u]   = ~w;
      end
    end
    addr[u] = 32'h0; wr[u] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int lat, acks; logic [31:0] rd;
    rst = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) begin
      n_vec++;
      if (ack[u] !== 1'b0 || dout[u] !== 32'h0) begin
        n_err++; $display("FAIL reset_state u%0d ack=%b dout=%h expected ack=0 dout=0", u, ack[u], dout[u]);
      end
      last_rd[u] = 32'h0;
    end
    @(negedge clk); rst = 1'b0;
    xfer(1, 32'h1000_0050, 1'b1, 32'h0BAD_F00D, 1, lat, acks, rd);
    mdl[1][8'h14] = 32'h0BAD_F00D; vld[1][8'h14] = 1'b1;
    xfer(1, 32'h1000_0050, 1'b0, 32'h0, 1, lat, acks, rd);
    n_vec++;
    if (rd !== 32'h0BAD_F00D) begin
      n_err++; $display("FAIL reset_preload got=%h expected=%h", rd, 32'h0BAD_F00D);
    end
    @(negedge clk);
    addr[1] = 32'h1000_0050; wr[1] = 1'b1; din[1] = 32'h5555_AAAA;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (ack[1] !== 1'b0 || dout[1] !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_wait ack=%b dout=%h expected ack=0 dout=0", ack[1], dout[1]);
    end
    @(negedge clk); rst = 1'b0; addr[1] = 32'h0; wr[1] = 1'b0;
    @(negedge clk);
    addr[1] = 32'h1000_0050;
    repeat (6) @(negedge clk);
    n_vec++;
    if (ack[1] !== 1'b1 || dout[1] !== 32'h0BAD_F00D) begin
      n_err++; $display("FAIL reset_pre_ack ack=%b dout=%h expected ack=1 dout=%h", ack[1], dout[1], 32'h0BAD_F00D);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (ack[1] !== 1'b0 || dout[1] !== 32'h0) begin
      n_err++; $display("FAIL reset_during_ack ack=%b dout=%h expected ack=0 dout=0", ack[1], dout[1]);
    end
    @(negedge clk); rst = 1'b0; addr[1] = 32'h0;
    for (int u = 0; u < 3; u++) last_rd[u] = 32'h0;
    xfer(1, 32'h1000_0050, 1'b0, 32'h0, 1, lat, acks, rd);
    n_vec++;
    if (rd !== 32'h0BAD_F00D || acks != 1) begin
      n_err++; $display("FAIL reset_no_commit got=%h acks=%0d expected=%h acks=1", rd, acks, 32'h0BAD_F00D);
    end
    last_rd[1] = 32'h0BAD_F00D;
  endtask

  task automatic test_write_read();
    int lat, acks; logic [31:0] rd;
    xfer(0, 32'h1000_0010, 1'b1, 32'hDEAD_BEEF, 2, lat, acks, rd);
    mdl[0][8'h04] = 32'hDEAD_BEEF; vld[0][8'h04] = 1'b1;
    n_vec++;
    if (lat != 3 || acks != 1) begin
      n_err++; $display("FAIL wr_latency lat=%0d acks=%0d expected lat=3 acks=1", lat, acks);
    end
    xfer(0, 32'h1000_0010, 1'b0, 32'h0, 2, lat, acks, rd);
    n_vec++;
    if (lat != 3 || acks != 1 || rd !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL rd_basic lat=%0d acks=%0d data=%h expected lat=3 acks=1 data=%h", lat, acks, rd, 32'hDEAD_BEEF);
    end
    last_rd[0] = 32'hDEAD_BEEF;
  endtask

  task automatic test_alias();
    int lat, acks; logic [31:0] rd;
    xfer(0, 32'h1000_0404, 1'b1, 32'h1234_5678, 1, lat, acks, rd);
    mdl[0][8'h01] = 32'h1234_5678; vld[0][8'h01] = 1'b1;
    xfer(0, 32'h1000_0004, 1'b0, 32'h0, 1, lat, acks, rd);
    n_vec++;
    if (rd !== 32'h1234_5678) begin
      n_err++; $display("FAIL alias_high got=%h expected=%h", rd, 32'h1234_5678);
    end
    xfer(0, 32'h1000_0006, 1'b0, 32'h0, 1, lat, acks, rd);
    n_vec++;
    if (rd !== 32'h1234_5678) begin
      n_err++; $display("FAIL alias_byte got=%h expected=%h", rd, 32'h1234_5678);
    end
    last_rd[0] = 32'h1234_5678;
  endtask

  task automatic test_hold();
    int lat, acks; logic [31:0] rd;
    xfer(0, 32'h1000_0020, 1'b1, 32'hCAFE_F00D, 1, lat, acks, rd);
    mdl[0][8'h08] = 32'hCAFE_F00D; vld[0][8'h08] = 1'b1;
    xfer(0, 32'h1000_0020, 1'b0, 32'h0, 10, lat, acks, rd);
    n_vec++;
    if (acks != 1 || rd !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL hold_single acks=%0d data=%h expected acks=1 data=%h", acks, rd, 32'hCAFE_F00D);
    end
    xfer(0, 32'h1000_0020, 1'b0, 32'h0, 1, lat, acks, rd);
    n_vec++;
    if (acks != 1 || lat != 3) begin
      n_err++; $display("FAIL hold_rearm acks=%0d lat=%0d expected acks=1 lat=3", acks, lat);
    end
    last_rd[0] = 32'hCAFE_F00D;
  endtask

  task automatic test_abort_mismatch();
    int lat, acks; logic [31:0] rd;
    xfer(1, 32'h1000_0030, 1'b1, 32'h1111_0000, 1, lat, acks, rd);
    mdl[1][8'h0C] = 32'h1111_0000; vld[1][8'h0C] = 1'b1;
    @(negedge clk);
    addr[1] = 32'h1000_0030; wr[1] = 1'b1; din[1] = 32'hAAAA_5555;
    repeat (2) @(negedge clk);
    addr[1] = 32'h0; wr[1] = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] === 1'b1) acks++;
    end
    n_vec++;
    if (acks != 0) begin
      n_err++; $display("FAIL abort_no_ack acks=%0d expected=0", acks);
    end
    xfer(1, 32'h1000_0030, 1'b0, 32'h0, 1, lat, acks, rd);
    n_vec++;
    if (rd !== 32'h1111_0000) begin
      n_err++; $display("FAIL abort_no_write got=%h expected=%h", rd, 32'h1111_0000);
    end
    last_rd[1] = 32'h1111_0000;
    xfer(0, 32'h2000_0030, 1'b0, 32'h0, 10, lat, acks, rd);
    n_vec++;
    if (acks != 0) begin
      n_err++; $display("FAIL mismatch_no_ack acks=%0d expected=0", acks);
    end
  endtask

  task automatic test_zero_wait();
    int lat, acks; logic [31:0] rd;
    xfer(2, 32'h1000_0000, 1'b1, 32'h600D_CAFE, 1, lat, acks, rd);
    mdl[2][8'h00] = 32'h600D_CAFE; vld[2][8'h00] = 1'b1;
    n_vec++;
    if (lat != 2 || acks != 1) begin
      n_err++; $display("FAIL zw_write lat=%0d acks=%0d expected lat=2 acks=1", lat, acks);
    end
    xfer(2, 32'h1000_0000, 1'b0, 32'h0, 1, lat, acks, rd);
    n_vec++;
    if (lat != 2 || rd !== 32'h600D_CAFE) begin
      n_err++; $display("FAIL zw_read lat=%0d data=%h expected lat=2 data=%h", lat, rd, 32'h600D_CAFE);
    end
    last_rd[2] = 32'h600D_CAFE;
  endtask

  task automatic test_random();
    int lat, acks, u, idx, extra;
    logic [31:0] a, d, rd;
    logic [3:0] tag;
    logic w;
    for (int it = 0; it < 120; it++) begin
      u     = $urandom_range(0, 2);
      idx   = $urandom_range(0, 255);
      extra = $urandom_range(1, 3);
      tag   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15)) : 4'h1;
      w     = !vld[u][idx] || ($urandom_range(0, 1) == 1);
      d     = $urandom;
      a     = {tag, 28'($urandom)};
      a[9:2] = 8'(idx);
      xfer(u, a, w, d, extra, lat, acks, rd);
      if (tag != 4'h1) begin
        n_vec++;
        if (acks != 0) begin
          n_err++; $display("FAIL rnd_mismatch it%0d u%0d acks=%0d expected=0", it, u, acks);
        end
      end else begin
        n_vec++;
        if (acks != 1 || lat != wc(u) + 2) begin
          n_err++; $display("FAIL rnd_timing it%0d u%0d acks=%0d lat=%0d expected acks=1 lat=%0d", it, u, acks, lat, wc(u) + 2);
        end
        if (w) begin
          mdl[u][idx] = d; vld[u][idx] = 1'b1;
          n_vec++;
          if (dout[u] !== last_rd[u]) begin
            n_err++; $display("FAIL rnd_dout_hold it%0d u%0d got=%h expected=%h", it, u, dout[u], last_rd[u]);
          end
        end else begin
          n_vec++;
          if (rd !== mdl[u][idx]) begin
            n_err++; $display("FAIL rnd_read it%0d u%0d idx=%0d got=%h expected=%h", it, u, idx, rd, mdl[u][idx]);
          end
          last_rd[u] = mdl[u][idx];
        end
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      addr[u] = 32'h0; din[u] = 32'h0; wr[u] = 1'b0; last_rd[u] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_alias();
    test_hold();
    test_abort_mismatch();
    test_zero_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
